// File: rtl/pipe_click_seq.sv
// pipe_click_seq
//   Clocked sequencer for an N-stage click-style data pipeline. Tracks which
//   stage holds a token, issues one-cycle capture strobes to the stage
//   registers and enforces a programmable minimum hold time per stage
//   (standing in for the matched delay of an asynchronous click chain).
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_start      upstream token valid
//   o_start_rdy  upstream token ready (accept = i_start && o_start_rdy)
//   i_gap        minimum hold cycles, latched per stage at capture
//   o_click      per-stage capture strobe (bit k enables stage register k)
//   o_out_vld    last stage holds a token whose hold has expired
//   i_out_rdy    downstream accepts the last-stage token
//   o_busy       any stage occupied
//   o_occ        number of occupied stages (registered state only)
//   o_tok_cnt    16-bit wrapping count of delivered tokens
//                (present only when PIPE_SEQ_CNT_EN is defined)
//
// Optional feature macro: PIPE_SEQ_CNT_EN
module pipe_click_seq #(
    parameter int NUM_STAGES = 3,
    parameter int GAP_W      = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    output logic                                  o_start_rdy,
    input  logic [GAP_W-1:0]                      i_gap,
    output logic [NUM_STAGES-1:0]                 o_click,
    output logic                                  o_out_vld,
    input  logic                                  i_out_rdy,
    output logic                                  o_busy,
    output logic [$clog2(NUM_STAGES+1)-1:0]       o_occ
`ifdef PIPE_SEQ_CNT_EN
    ,
    output logic [15:0]                           o_tok_cnt
`endif
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0]            full_q, full_d;
    logic [NUM_STAGES-1:0][GAP_W-1:0] hold_q, hold_d;

    logic [NUM_STAGES-1:0] avail;   // full and hold expired
    logic [NUM_STAGES-1:0] click;
    logic [NUM_STAGES-1:0] rel;     // stage k handing its token onward
    logic                  take;
    logic [OCC_W-1:0]      occ;

    always_comb begin
        avail  = '0;
        click  = '0;
        full_d = full_q;
        hold_d = hold_q;
        for (int k = 0; k < NUM_STAGES; k++) begin
            avail[k] = full_q[k] && (hold_q[k] == '0);
        end
        take = avail[NUM_STAGES-1] && i_out_rdy;

        // Ready ripples back from the output: a full stage can still capture
        // if its own token leaves in the same cycle.
        click[NUM_STAGES-1] = avail[NUM_STAGES-2] && (!full_q[NUM_STAGES-1] || take);
        for (int k = NUM_STAGES - 2; k >= 1; k--) begin
            click[k] = avail[k-1] && (!full_q[k] || click[k+1]);
        end
        click[0] = i_start && (!full_q[0] || click[1]);

        rel = {take, click[NUM_STAGES-1:1]};

        for (int k = 0; k < NUM_STAGES; k++) begin
            if (click[k]) begin
                // Capture wins over a same-cycle release (pass-through).
                full_d[k] = 1'b1;
                hold_d[k] = i_gap;
            end else begin
                if (rel[k]) begin
                    full_d[k] = 1'b0;
                end
                if (hold_q[k] != '0) begin
                    hold_d[k] = hold_q[k] - GAP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q <= '0;
            hold_q <= '0;
        end else begin
            full_q <= full_d;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            occ = occ + OCC_W'(full_q[k]);
        end
    end

    // Strobes are masked by reset so nothing fires once i_rst rises,
    // before the asynchronous clear has even propagated.
    assign o_click     = i_rst ? '0 : click;
    assign o_start_rdy = !i_rst && (!full_q[0] || click[1]);
    assign o_out_vld   = !i_rst && avail[NUM_STAGES-1];
    assign o_busy      = |full_q;
    assign o_occ       = occ;

`ifdef PIPE_SEQ_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (take) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign o_tok_cnt = cnt_q;
`endif

endmodule

// File: doc/pipe_click_seq.md
# pipe_click_seq

Synchronous sequencer for the N-stage click-style data pipeline. It accepts start tokens from upstream over a valid/ready handshake and tracks which stage holds a token. It issues one-cycle capture strobes `o_click[k]` that drive the stage-register enables of the datapath. It enforces a programmable minimum hold time per stage, which models the matched delay of the asynchronous click chain. The block sits between the token source and the stage registers and replaces free-running click generation in clocked builds.

## Interface
- `NUM_STAGES`, default 3: number of pipeline stages, ≥2.
- `GAP_W`, default 4: width of the per-stage hold counter and of `i_gap`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  upstream token valid.
- `o_start_rdy`  out  1  upstream token ready; a token is accepted when `i_start && o_start_rdy`.
- `i_gap`  in  GAP_W  minimum hold cycles, sampled per stage at capture.
- `o_click`  out  NUM_STAGES  one-cycle capture strobe per stage; bit k enables stage register k.
- `o_out_vld`  out  1  last stage holds a token.
- `i_out_rdy`  in  1  downstream accepts the last-stage token.
- `o_busy`  out  1  OR of all occupancy bits.
- `o_occ`  out  $clog2(NUM_STAGES+1)  number of occupied stages.

## Operation
- State per stage k: occupancy bit `full[k]` and hold counter `hold[k]`, GAP_W bits. There is no other FSM.
- `rdy_out[k]` = `hold[k]==0` when `full[k]`.
- `click[0]` = `i_start && (!full[0] || click[1])`.
- `click[k]`, 0<k<N-1 = `full[k-1] && rdy_out[k-1] && (!full[k] || click[k+1])`.
- `click[N-1]` = `full[N-2] && rdy_out[N-2] && (!full[N-1] || take)`.
- `take` = `full[N-1] && rdy_out[N-1] && i_out_rdy`.
- `o_start_rdy` = `!full[0] || click[1]`.
- `o_out_vld` = `full[N-1] && rdy_out[N-1]`.
- On `click[k]`: `full[k]` is set to 1 and `hold[k]` is loaded with `i_gap`. This takes priority over a same-cycle release.
- Release of stage k is `click[k+1]`, or `take` for the last stage. On release without a same-cycle click, `full[k]` is cleared.
- `hold[k]` decrements by 1 each cycle while nonzero and saturates at 0.
- Simultaneous click and release on the same stage is a pass-through. Occupancy stays 1 and `hold` is reloaded.
- All `o_click`, `o_start_rdy` and `o_out_vld` are forced to 0 while `i_rst` is high.

## Timing
- `o_click`, `o_start_rdy` and `o_out_vld` are combinational from registered state and current-cycle inputs (Mealy). The chain ready path is combinational, giving full throughput.
- Reset values: `full`=0, `hold`=0, `o_click`=0, `o_start_rdy`=0 during reset, `o_out_vld`=0, `o_busy`=0, `o_occ`=0.
- After reset release, `o_start_rdy`=1 in the first cycle.
- Latency with `i_gap`=g and `i_out_rdy`=1, for a token accepted in cycle 0:
  - `click[k]` fires in cycle k·(g+1).
  - `o_out_vld` rises in cycle N·(g+1) - g + g = (N-1)(g+1)+g+1.
  - With N=3, g=0: clicks in cycles 0, 1, 2; `o_out_vld` in cycle 3.
- Throughput is one token per g+1 cycles.
- Backpressure: with `i_out_rdy`=0, tokens stack; `o_start_rdy` falls once all N stages are full, and no `o_click` fires. When `i_out_rdy` rises, all stages shift in the same cycle.
- Reset mid-operation discards all tokens immediately, asynchronously. No strobe is emitted after `i_rst` rises.
- `i_gap` changes apply only to subsequent captures. A `hold` already loaded is not rewritten.
- `o_occ` counts set occupancy bits, registered state only.

## Configuration
- `PIPE_SEQ_CNT_EN` defined: adds output `o_tok_cnt`, 16 bits.
  - Increments on every `take` and wraps from 0xFFFF to 0.
  - Reset value 0.
- `PIPE_SEQ_CNT_EN` undefined: the port and the counter do not exist. All other behaviour is identical.

## Test plan
- Reset then single token, N=3, g=0, `i_out_rdy`=1: `i_start` pulse in cycle 0 → `o_click`=001, 010, 100 in cycles 0–2; `o_out_vld`=1 in cycle 3 only; `o_busy` returns to 0 in cycle 4.
- Streaming with g=0: `i_start`=1 for 8 cycles → `o_start_rdy` stays 1, 8 `o_out_vld` cycles back-to-back, `o_tok_cnt`=8 when the macro is enabled.
- Gap, g=2, single token: clicks in cycles 0, 3, 6; `o_out_vld` in cycle 9; `o_start_rdy`=0 for a second token in cycles 1–2.
- Backpressure: `i_out_rdy`=0, 4 offered tokens → 3 accepted, `o_occ`=3, `o_start_rdy`=0. Then `i_out_rdy`=1 for one cycle → `o_click`=111 that cycle and the 4th token is accepted.
- Reset mid-flight: assert `i_rst` with `o_occ`=2 → `o_click`=0, `o_occ`=0 and `o_out_vld`=0 immediately. After release, the first new token follows the single-token timing exactly.
- Counter wrap with macro enabled: preload or run 65 536 takes → `o_tok_cnt` reads 0 after the last take.
